pong_match_fsm: RTL and testbench
=================================

Name: pong_match_fsm

Overview:
Match/score controller for the Pong game. It consumes the ball controller's lost flags and the VGA frame timing. It produces the pause and serve controls for the ball controller, and the per-player score values for the two score digits. It sits between the ball controller's outputs and the digit and ball-control inputs. All timing is counted in video frames.

Parameters:
WIN_SCORE, 9, score at which a player wins the match (1..15)
SERVE_FRAMES, 60, frames the ball is held before each serve (1..255)
OVER_FRAMES, 180, frames the game-over state is held (1..255)
SCORE_W, 4, score output width

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-low reset
vsync  input  1  VGA vsync, active-low; comes from the 25 MHz pixel domain and is synchronised internally
start  input  1  start request, level; any paddle button ORed
leftlost  input  1  level; high while the ball is past the left edge
rightlost  input  1  level; high while the ball is past the right edge
paused  output  1  high whenever the state is not PLAY
serve  output  1  one-cycle pulse when the ball is released
serve_dir  output  1  ball direction at serve; 1 = toward the right, 0 = toward the left
left_score  output  SCORE_W  left player score
right_score  output  SCORE_W  right player score
winner  output  2  00 none, 01 left, 10 right, 11 unused
state_o  output  3  current state encoding, for debug LEDs

Behaviour:
Reset (rst low, asynchronous):
- state = IDLE; both scores = 0; winner = 00; serve = 0; serve_dir = 1; paused = 1; frame counter = 0; all edge registers = 0.

Frame tick:
- vsync passes through a 2-flop synchroniser, then a falling-edge detector.
- tick is a 1-cycle pulse, 3 clk cycles after the vsync falling edge.

Lost edges:
- leftlost and rightlost are each registered.
- lost_l_rise = leftlost & ~leftlost_q; lost_r_rise is defined the same way.
- Rise events are acted on only in PLAY. In every other state they are ignored.

States and transitions:
- IDLE: scores hold their last values. A start high sampled on a clk edge moves to SERVE on that edge. On that same edge: scores clear to 0, winner clears, frame counter clears, serve_dir = 1.
- SERVE: the frame counter increments on each tick. When the counter = SERVE_FRAMES-1 and a tick occurs: move to PLAY, serve = 1 for that one cycle, counter clears.
- PLAY:
  - lost_l_rise only: right_score += 1 and serve_dir = 0, on the edge entering POINT.
  - lost_r_rise only: left_score += 1 and serve_dir = 1, on the edge entering POINT.
  - Both rise in the same cycle: no score change, serve_dir unchanged, enter POINT.
- POINT (exactly 1 cycle):
  - If either score = WIN_SCORE: go to OVER, winner set accordingly, counter clears.
  - Otherwise: go to SERVE, counter clears.
- OVER: the counter increments on each tick. At OVER_FRAMES-1 with a tick: go to IDLE. start is ignored in OVER.

Arithmetic and boundaries:
- Scores saturate at WIN_SCORE and never wrap.
- The frame counter is 8 bits.
- A tick coinciding with a state entry is not counted.
- A start held through OVER takes effect on the first cycle in IDLE.
- A lost level that is still high when PLAY is re-entered scores no point, because only rising edges count.

Latency:
- Lost rising edge to score update: 2 clk cycles (input register, then state register).
- serve_dir is stable from POINT onward and throughout SERVE.

Reset mid-operation: returns immediately to the reset values above. No serve pulse is produced.

Optional Feature:
Macro PONG_AUTOSTART_EN.
- Defined: IDLE also counts ticks. After OVER_FRAMES ticks without start, it enters SERVE exactly as if start had been asserted (attract/demo mode). start still works earlier.
- Undefined: IDLE waits indefinitely for start, and no counter runs in IDLE.

Decomposition:
- Package pong_pkg:
  - state enum IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
  - winner codes
  - default SCORE_W
  - shared frame-count width (8)
- One sub-module: pong_frame_tick. It contains the vsync 2-flop synchroniser and falling-edge pulse; ports clk, rst, vsync, tick.

Test Plan:
1. Reset low mid-PLAY with scores 3/2 -> outputs immediately read 0/0, state IDLE, paused = 1, serve_dir = 1, winner = 00.
2. start pulse, then 60 vsync falls -> state SERVE; serve pulses once (1 cycle) 3 clk after the 60th fall; paused drops to 0 that same cycle.
3. In PLAY, raise leftlost -> 2 cycles later right_score = 1, serve_dir = 0, state POINT then SERVE. leftlost held high through the next PLAY -> no further increment.
4. leftlost and rightlost rising on the same cycle -> scores unchanged, back to SERVE.
5. left_score at 8, raise rightlost -> left_score = 9, winner = 01, OVER. After 180 frames -> IDLE with 9/x held. start -> scores clear.
6. With PONG_AUTOSTART_EN: sit in IDLE for 180 frames with no start -> enters SERVE, scores 0/0. Without the macro -> stays in IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and widths for the Pong match controller.
package pong_pkg;

    localparam int unsigned SCORE_W_DFLT = 4;
    localparam int unsigned FRAME_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_t;

    // Terminal count for a hold of n frames (counter runs 0..n-1).
    function automatic logic [FRAME_CNT_W-1:0] last_frame(input int unsigned n);
        return FRAME_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/pong_match_fsm_if.sv
// Ball-controller / score-digit side of the match controller.
interface pong_match_fsm_if
    import pong_pkg::*;
#(
    parameter int unsigned SCORE_W = SCORE_W_DFLT
);
    logic               start;
    logic               leftlost;
    logic               rightlost;
    logic               paused;
    logic               serve;
    logic               serve_dir;
    logic [SCORE_W-1:0] left_score;
    logic [SCORE_W-1:0] right_score;
    logic [1:0]         winner;
    logic [2:0]         state_o;

    modport master (
        output start, leftlost, rightlost,
        input  paused, serve, serve_dir, left_score, right_score, winner, state_o
    );

    modport slave (
        input  start, leftlost, rightlost,
        output paused, serve, serve_dir, left_score, right_score, winner, state_o
    );
endinterface

// File: rtl/pong_frame_tick.sv
// Frame tick: vsync synchroniser plus registered falling-edge pulse.
module pong_frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);
    logic sync1;
    logic sync2;
    logic sync2_q;

    // Two-flop synchroniser, edge history and registered falling-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync1   <= vsync;
            sync2   <= sync1;
            sync2_q <= sync2;
            tick    <= sync2_q & ~sync2;
        end
    end
endmodule

// File: rtl/pong_match_fsm.sv
// Pong match/score controller.
// Optional attract mode: define PONG_AUTOSTART_EN to auto-serve from IDLE.
module pong_match_fsm
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 180,
    parameter int unsigned SCORE_W      = SCORE_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    pong_match_fsm_if.slave  bus
);
    localparam logic [SCORE_W-1:0]     WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = last_frame(SERVE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] OVER_LAST  = last_frame(OVER_FRAMES);

    logic                   tick;
    logic                   ll_in;
    logic                   ll_q;
    logic                   rl_in;
    logic                   rl_q;
    logic                   lost_l_rise;
    logic                   lost_r_rise;
    logic                   idle_go;
    state_t                 state_q;
    winner_t                winner_q;
    logic [FRAME_CNT_W-1:0] cnt_q;
    logic [SCORE_W-1:0]     left_q;
    logic [SCORE_W-1:0]     right_q;
    logic                   serve_q;
    logic                   dir_q;
    logic                   paused_q;

    pong_frame_tick u_frame_tick (
        .clk   (clk),
        .rst   (rst),
        .vsync (vsync),
        .tick  (tick)
    );

    // Register the lost levels, then keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ll_in <= 1'b0;
            ll_q  <= 1'b0;
            rl_in <= 1'b0;
            rl_q  <= 1'b0;
        end else begin
            ll_in <= bus.leftlost;
            ll_q  <= ll_in;
            rl_in <= bus.rightlost;
            rl_q  <= rl_in;
        end
    end

    assign lost_l_rise = ll_in & ~ll_q;
    assign lost_r_rise = rl_in & ~rl_q;

`ifdef PONG_AUTOSTART_EN
    assign idle_go = bus.start | (tick && (cnt_q == OVER_LAST));
`else
    assign idle_go = bus.start;
`endif

    // Match state machine with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            winner_q <= WIN_NONE;
            cnt_q    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            serve_q  <= 1'b0;
            dir_q    <= 1'b1;
            paused_q <= 1'b1;
        end else begin
            serve_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (idle_go) begin
                        state_q  <= SERVE;
                        left_q   <= '0;
                        right_q  <= '0;
                        winner_q <= WIN_NONE;
                        cnt_q    <= '0;
                        dir_q    <= 1'b1;
                    end
`ifdef PONG_AUTOSTART_EN
                    else if (tick) begin
                        cnt_q <= cnt_q + FRAME_CNT_W'(1);
                    end
`endif
                end
                SERVE: begin
                    if (tick) begin
                        if (cnt_q == SERVE_LAST) begin
                            state_q  <= PLAY;
                            serve_q  <= 1'b1;
                            paused_q <= 1'b0;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + FRAME_CNT_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (lost_l_rise || lost_r_rise) begin
                        state_q  <= POINT;
                        paused_q <= 1'b1;
                        // Simultaneous losses cancel: no score, direction kept.
                        if (lost_l_rise && !lost_r_rise) begin
                            right_q <= (right_q >= WIN_VAL) ? right_q : right_q + SCORE_W'(1);
                            dir_q   <= 1'b0;
                        end else if (lost_r_rise && !lost_l_rise) begin
                            left_q <= (left_q >= WIN_VAL) ? left_q : left_q + SCORE_W'(1);
                            dir_q  <= 1'b1;
                        end
                    end
                end
                POINT: begin
                    cnt_q <= '0;
                    if (left_q == WIN_VAL) begin
                        state_q  <= OVER;
                        winner_q <= WIN_LEFT;
                    end else if (right_q == WIN_VAL) begin
                        state_q  <= OVER;
                        winner_q <= WIN_RIGHT;
                    end else begin
                        state_q <= SERVE;
                    end
                end
                OVER: begin
                    if (tick) begin
                        if (cnt_q == OVER_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + FRAME_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    paused_q <= 1'b1;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign bus.paused      = paused_q;
    assign bus.serve       = serve_q;
    assign bus.serve_dir   = dir_q;
    assign bus.left_score  = left_q;
    assign bus.right_score = right_q;
    assign bus.winner      = winner_q;
    assign bus.state_o     = state_q;

endmodule

// File: tb/tb_pong_match_fsm.sv
// Directed bench for pong_match_fsm; follows PONG_AUTOSTART_EN if defined.
module tb_pong_match_fsm;
    import pong_pkg::*;

    localparam int SERVE_FRAMES = 60;
    localparam int OVER_FRAMES  = 180;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic vsync = 1'b1;

    int checks         = 0;
    int failures       = 0;
    int serve_cnt      = 0;
    int serve_lat      = 0;
    int serve_unpaused = 0;

    pong_match_fsm_if bus ();

    pong_match_fsm #(
        .WIN_SCORE    (9),
        .SERVE_FRAMES (SERVE_FRAMES),
        .OVER_FRAMES  (OVER_FRAMES),
        .SCORE_W      (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .vsync (vsync),
        .bus   (bus)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8-cycle video frame; vsync falls at the start and any serve pulse is logged.
    task automatic frame();
        vsync = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.serve) begin
                serve_cnt++;
                serve_lat      = i;
                serve_unpaused = bus.paused ? 0 : 1;
            end
            if (i == 4) vsync = 1'b1;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    // Run frames until PLAY, bounded by slightly more than one serve hold.
    task automatic to_play();
        for (int f = 0; f < SERVE_FRAMES + 5 && bus.state_o != 3'd2; f++) frame();
        check("reach_play", bus.state_o, 2);
    endtask

    // Score one point: lost_left=1 gives right a point, 0 gives left a point.
    task automatic point(input bit lost_left);
        to_play();
        if (lost_left) bus.leftlost = 1'b1;
        else           bus.rightlost = 1'b1;
        cyc(2);
        check("point_state", bus.state_o, 3);
        bus.leftlost  = 1'b0;
        bus.rightlost = 1'b0;
        cyc(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.leftlost  = 1'b0;
        bus.rightlost = 1'b0;
        cyc(2);

        // Reset state.
        check("rst_state",  bus.state_o, 0);
        check("rst_paused", bus.paused, 1);
        check("rst_dir",    bus.serve_dir, 1);
        check("rst_winner", bus.winner, 0);
        check("rst_left",   bus.left_score, 0);
        check("rst_right",  bus.right_score, 0);
        check("rst_serve",  bus.serve, 0);
        rst = 1'b1;
        cyc(3);
        check("idle_wait", bus.state_o, 0);

        // Start, then exactly SERVE_FRAMES frames until the single serve pulse.
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check("start_serve", bus.state_o, 1);
        check("serve_paused", bus.paused, 1);
        serve_cnt = 0;
        frames(SERVE_FRAMES - 1);
        check("no_early_serve", serve_cnt, 0);
        check("still_serve", bus.state_o, 1);
        frame();
        check("serve_once", serve_cnt, 1);
        check("serve_latency", (serve_lat >= 3 && serve_lat <= 4) ? 1 : 0, 1);
        check("serve_unpaused", serve_unpaused, 1);
        check("play_state", bus.state_o, 2);
        check("play_paused", bus.paused, 0);

        // Left loses: right scores two cycles later, POINT then SERVE.
        bus.leftlost = 1'b1;
        cyc(1);
        check("lost_lat1_right", bus.right_score, 0);
        cyc(1);
        check("lost_right", bus.right_score, 1);
        check("lost_dir", bus.serve_dir, 0);
        check("lost_point", bus.state_o, 3);
        cyc(1);
        check("point_to_serve", bus.state_o, 1);
        // Level still high when PLAY resumes: no new point.
        to_play();
        cyc(3);
        check("held_no_point", bus.right_score, 1);
        check("held_play", bus.state_o, 2);
        bus.leftlost = 1'b0;
        cyc(1);

        // Both rise together: no score, direction kept.
        bus.leftlost  = 1'b1;
        bus.rightlost = 1'b1;
        cyc(2);
        check("both_point", bus.state_o, 3);
        check("both_left", bus.left_score, 0);
        check("both_right", bus.right_score, 1);
        check("both_dir", bus.serve_dir, 0);
        bus.leftlost  = 1'b0;
        bus.rightlost = 1'b0;
        cyc(1);
        check("both_serve", bus.state_o, 1);

        // Reach 3/2 and reset asynchronously mid-PLAY.
        point(1'b0);
        check("dir_right", bus.serve_dir, 1);
        point(1'b0);
        point(1'b0);
        point(1'b1);
        to_play();
        check("pre_rst_left", bus.left_score, 3);
        check("pre_rst_right", bus.right_score, 2);
        #5 rst = 1'b0;
        #1;
        check("arst_state",  bus.state_o, 0);
        check("arst_left",   bus.left_score, 0);
        check("arst_right",  bus.right_score, 0);
        check("arst_paused", bus.paused, 1);
        check("arst_dir",    bus.serve_dir, 1);
        check("arst_winner", bus.winner, 0);
        check("arst_serve",  bus.serve, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(2);

        // Left plays to WIN_SCORE.
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check("m2_serve", bus.state_o, 1);
        for (int p = 0; p < 8; p++) point(1'b0);
        check("left_8", bus.left_score, 8);
        check("right_0", bus.right_score, 0);
        to_play();
        bus.rightlost = 1'b1;
        cyc(2);
        check("left_9", bus.left_score, 9);
        check("win_point", bus.state_o, 3);
        check("win_not_yet", bus.winner, 0);
        cyc(1);
        bus.rightlost = 1'b0;
        check("over_state", bus.state_o, 4);
        check("over_winner", bus.winner, 1);
        check("over_paused", bus.paused, 1);
        frames(OVER_FRAMES - 1);
        check("over_hold", bus.state_o, 4);
        frame();
        check("over_idle", bus.state_o, 0);
        check("idle_left_held", bus.left_score, 9);
        check("idle_winner_held", bus.winner, 1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check("restart_serve", bus.state_o, 1);
        check("restart_left", bus.left_score, 0);
        check("restart_winner", bus.winner, 0);

        // IDLE with no start for OVER_FRAMES frames.
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        frames(OVER_FRAMES - 1);
        check("auto_idle_hold", bus.state_o, 0);
        frame();
`ifdef PONG_AUTOSTART_EN
        check("auto_serve", bus.state_o, 1);
        check("auto_left", bus.left_score, 0);
        check("auto_right", bus.right_score, 0);
`else
        check("no_auto", bus.state_o, 0);
        frames(5);
        check("no_auto_later", bus.state_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
